// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_cond_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fixup.
module muldiv_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_i,
    input  logic         neg_i,
    output logic [W-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + W'(1)) : in_i;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply, restoring divide.
// MULDIV_EARLY_TERM_EN: multiply leaves RUN as soon as the remaining multiplier is zero.
//   state | meaning
//   IDLE  | ready for a request
//   PREP  | operand magnitudes, result sign, divide-by-zero shortcut
//   RUN   | one shift-add / shift-subtract step per cycle
//   FIXUP | sign-correct and select the result word
//   DONE  | result held until the consumer takes it
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    state_e              state_q;
    logic [2:0]          f3_q;
    logic [XLEN-1:0]     op1_q;
    logic [XLEN-1:0]     op2_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [XLEN-1:0]     dvd_q;
    logic [XLEN-1:0]     rem_q;
    logic [XLEN-1:0]     dvsr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q;
    logic [XLEN-1:0]     result_q;
    logic                valid_q;
    logic                ready_q;
    logic                busy_q;

    logic                is_div;
    logic                is_rem;
    logic                sign1;
    logic                sign2;
    logic                res_neg;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic [XLEN-1:0]     rem_shift;
    logic                rem_ge;
    logic                run_last;
    logic                early_exit;
    logic [2*XLEN-1:0]   fix_in;
    logic [2*XLEN-1:0]   fix_out;
    logic [XLEN-1:0]     fix_word;

    always_comb begin
        is_div  = f3_is_div(f3_q);
        is_rem  = f3_q[2] & f3_q[1];
        sign1   = op1_q[XLEN-1] & ((f3_q == F3_MUL) | (f3_q == F3_MULH) | (f3_q == F3_MULHSU) |
                                   (f3_q == F3_DIV) | (f3_q == F3_REM));
        sign2   = op2_q[XLEN-1] & ((f3_q == F3_MUL) | (f3_q == F3_MULH) |
                                   (f3_q == F3_DIV) | (f3_q == F3_REM));
        res_neg = is_rem ? sign1 : (sign1 ^ sign2);

        rem_shift = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
        rem_ge    = (rem_shift >= dvsr_q);
        run_last  = (cnt_q == CNT_W'(ITERATIONS - 1));
`ifdef MULDIV_EARLY_TERM_EN
        early_exit = !is_div && (mplier_q == '0);
`else
        early_exit = 1'b0;
`endif

        if (!is_div) begin
            fix_in = acc_q;
        end else if (is_rem) begin
            fix_in = {{XLEN{1'b0}}, rem_q};
        end else begin
            fix_in = {{XLEN{1'b0}}, dvd_q};
        end
        // MUL and both divide flavours take the low word; the MULH family takes the high word.
        fix_word = ((f3_q == F3_MUL) || is_div) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
    end

    muldiv_cond_neg #(.W(XLEN)) u_abs1 (
        .in_i  (op1_q),
        .neg_i (sign1),
        .out_o (mag1)
    );

    muldiv_cond_neg #(.W(XLEN)) u_abs2 (
        .in_i  (op2_q),
        .neg_i (sign2),
        .out_o (mag2)
    );

    muldiv_cond_neg #(.W(2*XLEN)) u_fix (
        .in_i  (fix_in),
        .neg_i (neg_q),
        .out_o (fix_out)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else if (i_flush && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid && ready_q && !i_flush) begin
                        f3_q    <= i_funct3;
                        op1_q   <= i_op1;
                        op2_q   <= i_op2;
                        state_q <= ST_PREP;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PREP: begin
                    neg_q    <= res_neg;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    mcand_q  <= {{XLEN{1'b0}}, mag1};
                    mplier_q <= mag2;
                    dvd_q    <= mag1;
                    rem_q    <= '0;
                    dvsr_q   <= mag2;
                    if (is_div && (op2_q == '0)) begin
                        result_q <= is_rem ? op1_q : '1;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (early_exit) begin
                        state_q <= ST_FIXUP;
                    end else begin
                        if (is_div) begin
                            rem_q <= rem_ge ? (rem_shift - dvsr_q) : rem_shift;
                            dvd_q <= {dvd_q[XLEN-2:0], rem_ge};
                        end else begin
                            if (mplier_q[0]) begin
                                acc_q <= acc_q + mcand_q;
                            end
                            mcand_q  <= mcand_q << 1;
                            mplier_q <= mplier_q >> 1;
                        end
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (run_last) begin
                            state_q <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    result_q <= fix_word;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    // valid rises one cycle after the result register settles
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid  = valid_q;
    assign o_ready  = ready_q;
    assign o_busy   = busy_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model plus directed RV32M corner cases.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        in_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    bit          m_busy = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [31:0] m_res = 32'd0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (in_valid),
        .o_ready  (out_ready),
        .i_funct3 (funct3),
        .i_op1    (op1),
        .i_op2    (op2),
        .i_flush  (flush),
        .o_valid  (out_valid),
        .i_ready  (in_ready),
        .o_result (result),
        .o_busy   (busy)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ua, ub, p;
        longint unsigned pu;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (f3)
            3'b000: begin p = sa * sb; r = p[31:0]; end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin pu = longint'(ua) * longint'(ub); r = pu[63:32]; end
            3'b100: begin if (b == 32'd0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
            3'b101: begin if (b == 32'd0) r = 32'hFFFF_FFFF; else begin p = ua / ub; r = p[31:0]; end end
            3'b110: begin if (b == 32'd0) r = a; else begin p = sa % sb; r = p[31:0]; end end
            default: begin if (b == 32'd0) r = a; else begin p = ua % ub; r = p[31:0]; end end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] b);
        int n;
        if (f3[2] && (b == 32'd0)) return 2;
        n = 35;
`ifdef MULDIV_EARLY_TERM_EN
        if (!f3[2]) begin
            logic [31:0] m;
            int          bl;
            m  = ((f3 == 3'b000 || f3 == 3'b001) && b[31]) ? (32'd0 - b) : b;
            bl = 0;
            for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
            n = ((bl + 1 < 32) ? (bl + 1) : 32) + 3;
        end
`endif
        return n;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: one outstanding operation, result visible after its latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
        end else if (m_busy && flush) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid && !flush) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_res  = ref_result(funct3, op1, op2);
                m_lat  = ref_lat(funct3, op2);
            end
        end else if (m_age >= m_lat) begin
            if (in_ready) m_busy = 1'b0;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("ready", 32'(out_ready), 32'(!m_busy));
            check("valid", 32'(out_valid), 32'(m_busy && (m_age >= m_lat)));
            if (m_busy && (m_age >= m_lat)) check("result", result, m_res);
        end
    end

    task automatic issue_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res, input int exp_lat, input bit lit, input string nm);
        int n;
`ifdef MULDIV_EARLY_TERM_EN
        if (!f3[2]) exp_lat = ref_lat(f3, b);
`endif
        funct3   = f3;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            op1      = $urandom;
            op2      = $urandom;
            funct3   = 3'($urandom_range(0, 7));
            in_valid = (n == 3);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check($sformatf("%s_lat", nm), 32'(n), 32'(exp_lat));
        if (lit) check(nm, result, exp_res);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input bit lit, input string nm);
        issue_wait(f3, a, b, exp_res, exp_lat, lit, nm);
        @(posedge clk); #1;
        check($sformatf("%s_taken", nm), 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(out_ready), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 1'b1, "mul_neg");
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, 1'b1, "mulh_min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 1'b1, "mulhu_max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 1'b1, "mulhsu");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 1'b1, "div_neg");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 1'b1, "rem_neg");
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 35, 1'b1, "divu");
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 35, 1'b1, "remu");
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b1, "divu_zero");
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 2, 1'b1, "rem_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 1'b1, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 35, 1'b1, "rem_ovf");
        run_op(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 35, 1'b1, "divu_big");
        run_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 35, 1'b1, "remu_big");

        // backpressure: result must hold and new requests must be ignored
        in_ready = 1'b0;
        issue_wait(3'b000, 32'd6, 32'd7, 32'd42, 35, 1'b1, "bp_mul");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            funct3   = 3'b101;
            op1      = 32'd9;
            op2      = 32'd3;
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", result, 32'd42);
            check("bp_ready", 32'(out_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(out_ready), 32'd1);

        // flush during RUN iteration 10
        funct3   = 3'b000;
        op1      = 32'h0000_FFFF;
        op2      = 32'h0000_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_ready", 32'(out_ready), 32'd1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_result", result, 32'd42);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_valid", 32'(out_valid), 32'd0);

        // synchronous reset mid-RUN
        funct3   = 3'b100;
        op1      = 32'd1000;
        op2      = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(out_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'b000, 32'd3, 32'd4, 32'd12, 35, 1'b1, "mul_after");
        run_op(3'b000, 32'd3, 32'd1, 32'd3, 35, 1'b1, "mul_small");

        // flush in IDLE is ignored and blocks acceptance
        flush    = 1'b1;
        in_valid = 1'b1;
        funct3   = 3'b000;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("idle_flush_busy", 32'(busy), 32'd0);
        check("idle_flush_ready", 32'(out_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op(f3, a, b, 32'd0, ref_lat(f3, b), 1'b0, "rand");
        end

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
